// File: rtl/addr_arb_pkg.sv
// Shared types and constants for the address-path arbiter: FSM states,
// mux select encoding, counter widths and the starvation streak update.
package addr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS_A = 2'b01,
    BUS_B = 2'b10
  } arb_state_e;

  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;
  localparam int   STREAK_W = 4;
  localparam int   TIMER_W  = 8;

  // Streak after a B grant: counts only while A is waiting, saturates at lim.
  function automatic logic [STREAK_W-1:0] streak_next(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] lim,
    input logic                a_waiting
  );
    logic [STREAK_W-1:0] nxt;
    if (!a_waiting) begin
      nxt = {STREAK_W{1'b0}};
    end else if (cur >= lim) begin
      nxt = lim;
    end else begin
      nxt = cur + {{(STREAK_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/addr_mux_arb_if.sv
// Request/grant/memory handshake bundle between the CPU control side and
// the address-path arbiter.
interface addr_mux_arb_if;

  logic a_req;
  logic b_req;
  logic mem_ready;
  logic sel;
  logic mem_valid;
  logic gnt_a;
  logic gnt_b;
  logic a_done;
  logic b_done;
  logic timeout_err;
  logic busy;

  // Arbiter side: owns select, grants and the memory handshake.
  modport master (
    input  a_req, b_req, mem_ready,
    output sel, mem_valid, gnt_a, gnt_b, a_done, b_done, timeout_err, busy
  );

  // Requester/memory side.
  modport slave (
    output a_req, b_req, mem_ready,
    input  sel, mem_valid, gnt_a, gnt_b, a_done, b_done, timeout_err, busy
  );

endinterface

// File: rtl/addr_mux_arb_wait_timer.sv
// Grant watchdog: clearable cycle counter plus the expiry compare.
// TIMEOUT of 0 disables expiry entirely.
module wait_timer
  import addr_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic               WD_ON = (TIMEOUT != 0);
  localparam logic [TIMER_W-1:0] LAST  = (TIMEOUT == 0) ? {TIMER_W{1'b0}}
                                                        : TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_r;

  // Cycles elapsed since the current grant started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (clr) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = WD_ON && (count_r == LAST);

endmodule

// File: rtl/addr_mux_arb.sv
// Arbiter/sequencer for the shared address path: picks fetch (A) or operand (B),
// drives addr_mux select and owns the memory request until completion or timeout.
module addr_mux_arb
  import addr_arb_pkg::*;
#(
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  addr_mux_arb_if.master bus
);

  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIM);

  arb_state_e          state_r;
  logic                sel_r;
  logic                mem_valid_r;
  logic                gnt_a_r;
  logic                gnt_b_r;
  logic [STREAK_W-1:0] streak_r;

  logic expired_s;
  logic a_done_s;
  logic b_done_s;
  logic timeout_err_s;
  logic busy_s;
  logic a_starved_s;

  assign busy_s = (state_r != IDLE);

  // Timer is held at zero in IDLE, so each grant starts counting from 0.
  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!busy_s),
    .en      (busy_s),
    .expired (expired_s)
  );

  assign a_done_s      = gnt_a_r & (bus.mem_ready | expired_s);
  assign b_done_s      = gnt_b_r & (bus.mem_ready | expired_s);
  assign timeout_err_s = (gnt_a_r | gnt_b_r) & expired_s & ~bus.mem_ready;
  assign a_starved_s   = bus.a_req & (streak_r == LIM);

  // Arbitration FSM with registered grant, select, valid and starvation streak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sel_r       <= SEL_A;
      mem_valid_r <= 1'b0;
      gnt_a_r     <= 1'b0;
      gnt_b_r     <= 1'b0;
      streak_r    <= {STREAK_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.b_req && !a_starved_s) begin
            state_r     <= BUS_B;
            sel_r       <= SEL_B;
            gnt_b_r     <= 1'b1;
            mem_valid_r <= 1'b1;
            streak_r    <= streak_next(streak_r, LIM, bus.a_req);
          end else if (bus.a_req) begin
            state_r     <= BUS_A;
            sel_r       <= SEL_A;
            gnt_a_r     <= 1'b1;
            mem_valid_r <= 1'b1;
            streak_r    <= {STREAK_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        BUS_A: begin
          if (a_done_s) begin
            state_r     <= IDLE;
            gnt_a_r     <= 1'b0;
            mem_valid_r <= 1'b0;
          end else begin
            state_r <= BUS_A;
          end
        end
        BUS_B: begin
          if (b_done_s) begin
            state_r     <= IDLE;
            gnt_b_r     <= 1'b0;
            mem_valid_r <= 1'b0;
          end else begin
            state_r <= BUS_B;
          end
        end
        default: begin
          state_r     <= IDLE;
          sel_r       <= SEL_A;
          mem_valid_r <= 1'b0;
          gnt_a_r     <= 1'b0;
          gnt_b_r     <= 1'b0;
          streak_r    <= {STREAK_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.sel         = sel_r;
  assign bus.mem_valid   = mem_valid_r;
  assign bus.gnt_a       = gnt_a_r;
  assign bus.gnt_b       = gnt_b_r;
  assign bus.a_done      = a_done_s;
  assign bus.b_done      = b_done_s;
  assign bus.timeout_err = timeout_err_s;
  assign bus.busy        = busy_s;

endmodule
